serial_subtractor: RTL and testbench
====================================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, with all state updating on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: a synchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: an operation request, sampled only while ready=1.
REQ-005 The block SHALL have port A, input, WIDTH bits: the minuend.
REQ-006 The block SHALL have port B, input, WIDTH bits: the subtrahend.
REQ-007 The block SHALL have port Bi, input, 1 bit: the borrow-in.
REQ-008 The block SHALL have port ready, output, 1 bit: high when the block can accept start.
REQ-009 The block SHALL have port busy, output, 1 bit: high while bits are being processed.
REQ-010 The block SHALL have port done, output, 1 bit: a one-cycle pulse marking the result as valid.
REQ-011 The block SHALL have port D, output, WIDTH bits: the difference.
REQ-012 The block SHALL have port Bo, output, 1 bit: the borrow-out.

Function
REQ-013 The FSM SHALL have states IDLE, SHIFT and DONE.
REQ-014 In IDLE, ready=1 and busy=0; on start=1 the block SHALL capture A, B and Bi into internal registers, clear the bit counter and move to SHIFT.
REQ-015 In SHIFT, the block SHALL process one bit per cycle, LSB first: d_i = a_i^b_i^br; br' = (~a_i&b_i)|(~a_i&br)|(b_i&br), with br initialised to Bi.
REQ-016 After exactly WIDTH SHIFT cycles, the block SHALL move to DONE.
REQ-017 In DONE, done=1 for exactly one cycle and the FSM SHALL return to IDLE on the next edge.
REQ-018 Latency: for start accepted at edge t, done SHALL be high in the cycle following edge t+WIDTH+1.
REQ-019 D SHALL equal (A - B - Bi) mod 2^WIDTH, and Bo SHALL be 1 iff A < B+Bi (unsigned).
REQ-020 D and Bo SHALL update only when entering DONE and SHALL hold until the next completed operation.
REQ-021 start SHALL be ignored while busy=1 or done=1, and A, B and Bi SHALL NOT affect an operation in progress.
REQ-022 start held high continuously SHALL launch back-to-back operations, each accepted in the IDLE cycle.
REQ-023 The boundary case A=B with Bi=0 SHALL give D=0, Bo=0; the case A=0, B=2^WIDTH-1, Bi=1 SHALL give D=0, Bo=1.

Reset
REQ-024 rst=1 SHALL force IDLE, ready=1, busy=0, done=0, D=0, Bo=0, and clear the counter and operand registers.
REQ-025 rst SHALL take priority over start, and asserting rst mid-SHIFT SHALL abort the operation with no done pulse.

Configuration
REQ-026 With macro SERIAL_SUBTRACTOR_OVF_EN defined, the block SHALL add output ovf (1 bit), valid alongside D, equal to (A[W-1]!=B[W-1])&&(D[W-1]!=A[W-1]), reset to 0.
REQ-027 With SERIAL_SUBTRACTOR_OVF_EN undefined, the ovf port and its logic SHALL be absent, and all other behaviour SHALL be unchanged.

Structure
REQ-028 The state encoding (IDLE/SHIFT/DONE) and the default WIDTH constant SHALL reside in the shared package serial_arith_pkg.
REQ-029 The one-bit difference/borrow cell SHALL be a separate combinational sub-module, full_subtractor (ports A, B, Bi, D, Bo), instantiated once and fed from shift registers.

Verification
REQ-030 WIDTH=8, A=0x05, B=0x03, Bi=0, start for 1 cycle -> done after 9 edges, with D=0x02, Bo=0.
REQ-031 A=0x00, B=0x01, Bi=0 -> D=0xFF, Bo=1; A=0x00, B=0x00, Bi=1 -> D=0xFF, Bo=1.
REQ-032 With OVF_EN defined, A=0x80, B=0x01 -> D=0x7F, ovf=1; A=0x10, B=0x01 -> ovf=0.
REQ-033 Start with A=0x0A, B=0x04, then pulse start with A=0xFF, B=0x00 at cycle 3 of SHIFT -> a single done pulse, with D=0x06.
REQ-034 Assert rst at cycle 4 of SHIFT -> no done pulse, D=0, Bo=0, ready=1 on the next cycle; a new operation then completes correctly.
REQ-035 WIDTH=4, all 512 combinations of A, B and Bi issued back-to-back -> every D and Bo matches the reference arithmetic of REQ-019.

Source files
------------

// File: rtl/serial_arith_pkg.sv
// Shared definitions for the serial arithmetic blocks.
//
// Contents:
//   DEFAULT_WIDTH - default operand width used by serial_subtractor and its
//                   interface.
//   state_t       - control state encoding (IDLE / SHIFT / DONE).
//   cnt_width()   - width of a counter that must hold the values 0..width.
package serial_arith_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // The bit counter has to reach WIDTH itself (not just WIDTH-1), because the
  // SHIFT state uses count==WIDTH to detect that all bits have been processed.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Request/result bundle for serial_subtractor.
//
// Signals:
//   start    - operation request (sampled by the block only while ready=1)
//   A, B     - minuend / subtrahend, WIDTH bits
//   Bi       - borrow-in
//   ready    - block is idle and will accept start
//   busy     - block is processing bits
//   done     - one-cycle pulse, D/Bo (and ovf) are valid from this cycle
//   D, Bo    - difference and borrow-out, held until the next completion
//   ovf      - signed overflow flag, only present when SERIAL_SUBTRACTOR_OVF_EN
//              is defined
//
// Modports:
//   master - requester side (drives start/A/B/Bi)
//   slave  - the serial_subtractor side
interface serial_subtractor_if
  import serial_arith_pkg::*;
  #(parameter int WIDTH = DEFAULT_WIDTH)
  ();

  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Bi;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] D;
  logic             Bo;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic             ovf;
`endif

  modport master (
    output start, A, B, Bi,
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    input  ovf,
`endif
    input  ready, busy, done, D, Bo
  );

  modport slave (
    input  start, A, B, Bi,
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    output ovf,
`endif
    output ready, busy, done, D, Bo
  );

endinterface

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: computes A - B - Bi.
//
// Ports:
//   A  - minuend bit
//   B  - subtrahend bit
//   Bi - borrow in
//   D  - difference bit
//   Bo - borrow out
module full_subtractor (
  input  logic A,
  input  logic B,
  input  logic Bi,
  output logic D,
  output logic Bo
);

  assign D  = A ^ B ^ Bi;
  assign Bo = (~A & B) | (~A & Bi) | (B & Bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes D = A - B - Bi one bit per clock, LSB
// first, through a single full_subtractor cell fed from shift registers.
//
// Ports:
//   clk - clock, all state updates on the rising edge
//   rst - synchronous active-high reset
//   bus - serial_subtractor_if.slave (start/A/B/Bi in, ready/busy/done/D/Bo out)
//
// Timing: start accepted at edge t (IDLE -> SHIFT). Bits are shifted at
// edges t+1..t+WIDTH, the block enters DONE at edge t+WIDTH+1 (done high for
// one cycle, D/Bo loaded) and returns to IDLE on the following edge.
//
// Optional feature: define SERIAL_SUBTRACTOR_OVF_EN to add the signed
// overflow output bus.ovf, valid alongside D.
module serial_subtractor
  import serial_arith_pkg::*;
  #(parameter int WIDTH = DEFAULT_WIDTH)
  (
    input  logic                clk,
    input  logic                rst,
    serial_subtractor_if.slave  bus
  );

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [WIDTH-1:0] a_sr_reg, a_sr_next;
  logic [WIDTH-1:0] b_sr_reg, b_sr_next;
  logic [WIDTH-1:0] d_sr_reg, d_sr_next;
  logic             br_reg, br_next;
  logic [WIDTH-1:0] d_out_reg, d_out_next;
  logic             bo_out_reg, bo_out_next;
  logic             cell_d;
  logic             cell_bo;

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  // The operand MSBs are shifted out during SHIFT, so keep copies for the
  // overflow decision made when entering DONE.
  logic a_msb_reg, a_msb_next;
  logic b_msb_reg, b_msb_next;
  logic ovf_reg, ovf_next;
`endif

  full_subtractor u_cell (
    .A  (a_sr_reg[0]),
    .B  (b_sr_reg[0]),
    .Bi (br_reg),
    .D  (cell_d),
    .Bo (cell_bo)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      a_sr_reg   <= '0;
      b_sr_reg   <= '0;
      d_sr_reg   <= '0;
      br_reg     <= 1'b0;
      d_out_reg  <= '0;
      bo_out_reg <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      a_msb_reg  <= 1'b0;
      b_msb_reg  <= 1'b0;
      ovf_reg    <= 1'b0;
`endif
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      a_sr_reg   <= a_sr_next;
      b_sr_reg   <= b_sr_next;
      d_sr_reg   <= d_sr_next;
      br_reg     <= br_next;
      d_out_reg  <= d_out_next;
      bo_out_reg <= bo_out_next;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      a_msb_reg  <= a_msb_next;
      b_msb_reg  <= b_msb_next;
      ovf_reg    <= ovf_next;
`endif
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    a_sr_next   = a_sr_reg;
    b_sr_next   = b_sr_reg;
    d_sr_next   = d_sr_reg;
    br_next     = br_reg;
    d_out_next  = d_out_reg;
    bo_out_next = bo_out_reg;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    a_msb_next  = a_msb_reg;
    b_msb_next  = b_msb_reg;
    ovf_next    = ovf_reg;
`endif

    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          a_sr_next  = bus.A;
          b_sr_next  = bus.B;
          br_next    = bus.Bi;
          d_sr_next  = '0;
          cnt_next   = '0;
          state_next = SHIFT;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
          a_msb_next = bus.A[WIDTH-1];
          b_msb_next = bus.B[WIDTH-1];
`endif
        end
      end

      SHIFT: begin
        if (cnt_reg == LAST_CNT) begin
          // All bits processed: d_sr holds the full difference and br the
          // final borrow. Results are published only here.
          d_out_next  = d_sr_reg;
          bo_out_next = br_reg;
          state_next  = DONE;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
          ovf_next    = (a_msb_reg != b_msb_reg) && (d_sr_reg[WIDTH-1] != a_msb_reg);
`endif
        end else begin
          // Difference bits enter at the MSB so that after WIDTH shifts the
          // first (LSB) result bit has arrived at position 0.
          a_sr_next = a_sr_reg >> 1;
          b_sr_next = b_sr_reg >> 1;
          d_sr_next = {cell_d, d_sr_reg[WIDTH-1:1]};
          br_next   = cell_bo;
          cnt_next  = cnt_reg + 1'b1;
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.ready = (state_reg == IDLE);
  assign bus.busy  = (state_reg == SHIFT);
  assign bus.done  = (state_reg == DONE);
  assign bus.D     = d_out_reg;
  assign bus.Bo    = bo_out_reg;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  assign bus.ovf   = ovf_reg;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Testbench for serial_subtractor: an 8-bit instance for directed, random,
// start-while-busy and reset-abort scenarios, and a 4-bit instance driven
// with every A/B/Bi combination back-to-back (start held high).
// Define SERIAL_SUBTRACTOR_OVF_EN to also check the ovf output.
module tb_serial_subtractor;
  import serial_arith_pkg::*;

  localparam int W8 = 8;
  localparam int W4 = 4;

  logic clk = 1'b0;
  logic rst8;
  logic rst4;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(W8)) if8 ();
  serial_subtractor_if #(.WIDTH(W4)) if4 ();

  serial_subtractor #(.WIDTH(W8)) dut8 (.clk(clk), .rst(rst8), .bus(if8));
  serial_subtractor #(.WIDTH(W4)) dut4 (.clk(clk), .rst(rst4), .bus(if4));

  // Reference arithmetic: plain integer subtraction, reduced modulo 2^w.
  task automatic ref_sub(input int w, input int a, input int b, input int bi,
                         output int d, output bit bo);
    int diff;
    diff = a - b - bi;
    bo   = (diff < 0);
    d    = (diff + (1 << w)) % (1 << w);
  endtask

  // Signed overflow of a - b, decided from operand and result sign bits.
  function automatic bit ref_ovf8(input int a, input int b, input int d);
    return (a[7] != b[7]) && (d[7] != a[7]);
  endfunction

  // Runs one operation on the 8-bit instance from an IDLE cycle. Operand
  // inputs are scrambled after acceptance. Returns the number of edges from
  // acceptance to the first done, busy-cycle count, done-pulse count and the
  // results sampled in the done cycle. Returns at posedge+1 with start low.
  task automatic do_op8(input logic [7:0] a, input logic [7:0] b, input logic bi,
                        output int lat, output int busy_cyc, output int pulses,
                        output logic [7:0] d, output logic bo, output logic ovf);
    if8.A = a; if8.B = b; if8.Bi = bi; if8.start = 1'b1;
    @(posedge clk); #1;
    if8.start = 1'b0;
    lat = -1; busy_cyc = 0; pulses = 0; d = 'x; bo = 1'bx; ovf = 1'b0;
    for (int c = 0; c < 14; c++) begin
      if (if8.busy) busy_cyc++;
      if (if8.done) begin
        pulses++;
        if (lat < 0) begin
          lat = c;
          d   = if8.D;
          bo  = if8.Bo;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
          ovf = if8.ovf;
`endif
        end
      end
      if8.A  = 8'($urandom);
      if8.B  = 8'($urandom);
      if8.Bi = 1'($urandom);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst8 = 1'b1; rst4 = 1'b1;
    if8.start = 1'b1; if8.A = 8'h55; if8.B = 8'h11; if8.Bi = 1'b0;
    if4.start = 1'b0; if4.A = '0; if4.B = '0; if4.Bi = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    $display("reset: ready=%0b busy=%0b done=%0b D=%02h Bo=%0b",
             if8.ready, if8.busy, if8.done, if8.D, if8.Bo);
    tests_run++;
    if (if8.ready !== 1'b1 || if8.busy !== 1'b0 || if8.done !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_flags: ready=%0b busy=%0b done=%0b, want 1 0 0",
               if8.ready, if8.busy, if8.done);
    end
    tests_run++;
    if (if8.D !== 8'h00 || if8.Bo !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_result: D=%02h Bo=%0b, want 00 0", if8.D, if8.Bo);
    end
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    tests_run++;
    if (if8.ovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ovf: ovf=%0b, want 0", if8.ovf);
    end
`endif
    tests_run++;
    if (if4.ready !== 1'b1 || if4.busy !== 1'b0 || if4.D !== 4'h0) begin
      tests_failed++;
      $display("FAIL reset_w4: ready=%0b busy=%0b D=%0h, want 1 0 0",
               if4.ready, if4.busy, if4.D);
    end
    if8.start = 1'b0;
    rst8 = 1'b0; rst4 = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic check_op8(input string name, input logic [7:0] a, input logic [7:0] b,
                           input logic bi);
    int lat, busy_cyc, pulses, exp_d;
    bit exp_bo;
    logic [7:0] d;
    logic bo, ovf;
    ref_sub(W8, int'(a), int'(b), int'(bi), exp_d, exp_bo);
    do_op8(a, b, bi, lat, busy_cyc, pulses, d, bo, ovf);
    $display("%s: A=%02h B=%02h Bi=%0b -> D=%02h Bo=%0b lat=%0d busy=%0d pulses=%0d",
             name, a, b, bi, d, bo, lat, busy_cyc, pulses);
    tests_run++;
    if (d !== 8'(exp_d) || bo !== exp_bo) begin
      tests_failed++;
      $display("FAIL %s_result: D=%02h Bo=%0b, want D=%02h Bo=%0b",
               name, d, bo, 8'(exp_d), exp_bo);
    end
    tests_run++;
    if (lat != W8 + 1 || pulses != 1 || busy_cyc != W8 + 1) begin
      tests_failed++;
      $display("FAIL %s_timing: lat=%0d pulses=%0d busy=%0d, want %0d 1 %0d",
               name, lat, pulses, busy_cyc, W8 + 1, W8 + 1);
    end
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    tests_run++;
    if (ovf !== ref_ovf8(int'(a), int'(b), exp_d)) begin
      tests_failed++;
      $display("FAIL %s_ovf: ovf=%0b, want %0b", name, ovf, ref_ovf8(int'(a), int'(b), exp_d));
    end
`endif
  endtask

  task automatic test_directed();
    logic [16:0] vec [9];
    vec = '{ {8'h05, 8'h03, 1'b0}, {8'h00, 8'h01, 1'b0}, {8'h00, 8'h00, 1'b1},
             {8'h5A, 8'h5A, 1'b0}, {8'h00, 8'hFF, 1'b1}, {8'h80, 8'h01, 1'b0},
             {8'h10, 8'h01, 1'b0}, {8'hFF, 8'hFF, 1'b1}, {8'hFF, 8'h00, 1'b0} };
    for (int i = 0; i < 9; i++)
      check_op8("directed", vec[i][16:9], vec[i][8:1], vec[i][0]);
  endtask

  task automatic test_random();
    for (int i = 0; i < 25; i++)
      check_op8("random", 8'($urandom), 8'($urandom), 1'($urandom));
  endtask

  // A second start pulse during SHIFT must not launch another operation
  // nor disturb the one in progress.
  task automatic test_start_while_busy();
    int pulses;
    logic [7:0] d;
    logic bo;
    pulses = 0; d = 'x; bo = 1'bx;
    if8.A = 8'h0A; if8.B = 8'h04; if8.Bi = 1'b0; if8.start = 1'b1;
    @(posedge clk); #1;
    if8.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    if8.A = 8'hFF; if8.B = 8'h00; if8.Bi = 1'b0; if8.start = 1'b1;
    tests_run++;
    if (if8.busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL busy_start_state: busy=%0b, want 1", if8.busy);
    end
    @(posedge clk); #1;
    if8.start = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (if8.done) begin
        pulses++;
        d  = if8.D;
        bo = if8.Bo;
      end
      @(posedge clk); #1;
    end
    $display("busy_start: D=%02h Bo=%0b pulses=%0d", d, bo, pulses);
    tests_run++;
    if (pulses != 1 || d !== 8'h06 || bo !== 1'b0) begin
      tests_failed++;
      $display("FAIL busy_start: pulses=%0d D=%02h Bo=%0b, want 1 06 0", pulses, d, bo);
    end
  endtask

  // Reset asserted in the fourth SHIFT cycle aborts the operation.
  task automatic test_reset_abort();
    int pulses;
    pulses = 0;
    if8.A = 8'h77; if8.B = 8'h12; if8.Bi = 1'b1; if8.start = 1'b1;
    @(posedge clk); #1;
    if8.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst8 = 1'b1;
    @(posedge clk); #1;
    rst8 = 1'b0;
    $display("reset_abort: ready=%0b busy=%0b D=%02h Bo=%0b", if8.ready, if8.busy, if8.D, if8.Bo);
    tests_run++;
    if (if8.ready !== 1'b1 || if8.busy !== 1'b0 || if8.D !== 8'h00 || if8.Bo !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_abort_state: ready=%0b busy=%0b D=%02h Bo=%0b, want 1 0 00 0",
               if8.ready, if8.busy, if8.D, if8.Bo);
    end
    for (int c = 0; c < 15; c++) begin
      if (if8.done) pulses++;
      @(posedge clk); #1;
    end
    tests_run++;
    if (pulses != 0) begin
      tests_failed++;
      $display("FAIL reset_abort_done: pulses=%0d, want 0", pulses);
    end
    check_op8("after_abort", 8'h77, 8'h12, 1'b0);
  endtask

  // Every 4-bit A/B/Bi combination, shuffled, with start held high.
  task automatic test_back_to_back();
    int perm [512];
    int acc_idx_q [$];
    int acc_cyc_q [$];
    int idx, done_cnt, last_acc, tmp, j, cur, acc_c, exp_d;
    bit exp_bo;
    logic prev_ready;
    for (int i = 0; i < 512; i++) perm[i] = i;
    for (int i = 511; i > 0; i--) begin
      j = int'($urandom_range(i, 0));
      tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
    end
    idx = 0; done_cnt = 0; last_acc = -1;
    if4.A = 4'(perm[0]); if4.B = 4'(perm[0] >> 4); if4.Bi = 1'(perm[0] >> 8);
    if4.start = 1'b1;
    prev_ready = if4.ready;
    for (int cyc = 1; cyc <= 512 * 7 + 40 && done_cnt < 512; cyc++) begin
      @(posedge clk); #1;
      if (prev_ready && if4.start) begin
        acc_idx_q.push_back(perm[idx]);
        acc_cyc_q.push_back(cyc);
        if (last_acc >= 0) begin
          tests_run++;
          if (cyc - last_acc != W4 + 3) begin
            tests_failed++;
            $display("FAIL b2b_spacing: %0d cycles between accepts, want %0d",
                     cyc - last_acc, W4 + 3);
          end
        end
        last_acc = cyc;
        idx++;
        if (idx == 512) if4.start = 1'b0;
      end
      if (if4.done) begin
        tests_run++;
        if (acc_idx_q.size() == 0) begin
          tests_failed++;
          $display("FAIL b2b_unexpected_done: D=%0h Bo=%0b, want no done", if4.D, if4.Bo);
        end else begin
          cur   = acc_idx_q.pop_front();
          acc_c = acc_cyc_q.pop_front();
          ref_sub(W4, cur & 15, (cur >> 4) & 15, (cur >> 8) & 1, exp_d, exp_bo);
          $display("b2b: A=%0h B=%0h Bi=%0b -> D=%0h Bo=%0b lat=%0d",
                   cur & 15, (cur >> 4) & 15, (cur >> 8) & 1, if4.D, if4.Bo, cyc - acc_c);
          if (if4.D !== 4'(exp_d) || if4.Bo !== exp_bo || cyc - acc_c != W4 + 1) begin
            tests_failed++;
            $display("FAIL b2b_op: A=%0h B=%0h Bi=%0b got D=%0h Bo=%0b lat=%0d, want D=%0h Bo=%0b lat=%0d",
                     cur & 15, (cur >> 4) & 15, (cur >> 8) & 1, if4.D, if4.Bo, cyc - acc_c,
                     4'(exp_d), exp_bo, W4 + 1);
          end
        end
        done_cnt++;
      end
      if (idx < 512) begin
        if (if4.ready) begin
          if4.A  = 4'(perm[idx]);
          if4.B  = 4'(perm[idx] >> 4);
          if4.Bi = 1'(perm[idx] >> 8);
        end else begin
          if4.A  = 4'($urandom);
          if4.B  = 4'($urandom);
          if4.Bi = 1'($urandom);
        end
      end
      prev_ready = if4.ready;
    end
    tests_run++;
    if (done_cnt != 512) begin
      tests_failed++;
      $display("FAIL b2b_count: %0d completions, want 512", done_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_while_busy();
    test_reset_abort();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, want completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
